// File: rtl/seq_booth_square.sv
// Sequential radix-4 Booth squarer: one partial square per clock, valid/ready on both sides.
// Ports: clk, rst, in_valid/in_ready/x_in, out_valid/out_ready/y_out, busy. Option: SEQ_BOOTH_SQUARE_EARLY_EXIT_EN.
module seq_booth_square #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y_out,
  output logic               busy
);

  localparam int NDIG = WIDTH / 2 + 1;
  localparam int AW   = 2 * WIDTH + 2;
  localparam int KW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] xr;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_nxt;
  logic [AW-1:0]    mag;
  logic [AW-1:0]    term;
  logic [KW-1:0]    k;
  logic [WIDTH+2:0] ext;
  logic [2:0]       trip;
  logic             neg;
  logic             last;

  // xr with the implicit xr[-1]=0 below and zero bits above,
  // so digit k is the 3-bit window starting at bit 2k.
  assign ext = {2'b00, xr, 1'b0};

  always_comb begin
    trip = 3'(ext >> {k, 1'b0});
    mag  = '0;
    neg  = 1'b0;
    case (trip)
      3'b001, 3'b010: mag = AW'(xr);
      3'b011:         mag = AW'(xr) << 1;
      3'b100: begin
        mag = AW'(xr) << 1;
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = AW'(xr);
        neg = 1'b1;
      end
      default:        mag = '0;
    endcase
    term    = mag << {k, 1'b0};
    acc_nxt = neg ? acc - term : acc + term;
  end

`ifdef SEQ_BOOTH_SQUARE_EARLY_EXIT_EN
  // Once xr >> (2k+1) is zero every later window is 000.
  always_comb begin
    last = (k == KW'(NDIG - 1)) || ((xr >> {k, 1'b1}) == '0);
  end
`else
  always_comb begin
    last = (k == KW'(NDIG - 1));
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == BUSY);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xr    <= '0;
      acc   <= '0;
      k     <= '0;
      y_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr  <= x_in;
            acc <= '0;
            k   <= '0;
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          k   <= k + KW'(1);
          if (last) y_out <= acc_nxt[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_booth_square.sv
// Testbench for seq_booth_square: directed WIDTH=16 scenarios plus
// randomized traffic over WIDTH 4/8/16/32 against an arithmetic model.
module tb_seq_booth_square;

  logic        clk;
  logic        rst;
  logic        iv   [4];
  logic        ord  [4];
  logic        irdy [4];
  logic        ov   [4];
  logic        bsy  [4];
  logic [31:0] xin  [4];
  logic [63:0] yo   [4];
  logic [7:0]  y4;
  logic [15:0] y8;
  logic [31:0] y16;
  logic [63:0] y32;

  int errors;
  int checks;

  localparam int I16 = 2;
  int wtab [4] = '{4, 8, 16, 32};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    yo[0] = 64'(y4);
    yo[1] = 64'(y8);
    yo[2] = 64'(y16);
    yo[3] = y32;
  end

  seq_booth_square #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
    .x_in(xin[0][3:0]), .out_valid(ov[0]), .out_ready(ord[0]),
    .y_out(y4), .busy(bsy[0]));
  seq_booth_square #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
    .x_in(xin[1][7:0]), .out_valid(ov[1]), .out_ready(ord[1]),
    .y_out(y8), .busy(bsy[1]));
  seq_booth_square #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
    .x_in(xin[2][15:0]), .out_valid(ov[2]), .out_ready(ord[2]),
    .y_out(y16), .busy(bsy[2]));
  seq_booth_square #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(irdy[3]),
    .x_in(xin[3]), .out_valid(ov[3]), .out_ready(ord[3]),
    .y_out(y32), .busy(bsy[3]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges from the accepting edge (counted as 1) to out_valid.
  function automatic int lat_model(input logic [63:0] x, input int w);
    int nd;
    int p;
    nd = w / 2 + 1;
    p  = nd;
`ifdef SEQ_BOOTH_SQUARE_EARLY_EXIT_EN
    p = 1;
    while (p < nd && (x >> (2 * p - 1)) != 0) p++;
`endif
    return p + 1;
  endfunction

  // One full transaction; outputs describe what happened, callers compare.
  task automatic xact(input int i, input logic [63:0] xv, input bit rnd_bp,
                      output logic [63:0] yv, output int lat,
                      output bit acc_ok, output bit res_ok,
                      output bit stable);
    int n;
    acc_ok = 1'b0;
    res_ok = 1'b0;
    stable = 1'b1;
    yv     = '0;
    lat    = 0;
    xin[i] = xv[31:0];
    iv[i]  = 1'b1;
    n = 0;
    while (!irdy[i] && n < 200) begin
      step();
      n++;
    end
    if (!irdy[i]) begin
      iv[i] = 1'b0;
      return;
    end
    step();
    acc_ok = 1'b1;
    iv[i]  = 1'b0;
    xin[i] = $urandom;
    lat = 1;
    while (!ov[i] && lat < 200) begin
      step();
      lat++;
    end
    if (!ov[i]) return;
    res_ok = 1'b1;
    yv = yo[i];
    n = 0;
    do begin
      ord[i] = rnd_bp ? 1'($urandom % 2) : 1'b1;
      if (n > 50) ord[i] = 1'b1;
      if (yo[i] !== yv || !ov[i]) stable = 1'b0;
      step();
      n++;
    end while (!ord[i]);
    ord[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (irdy[I16] !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b want=1", irdy[I16]);
    end
    checks++;
    if (ov[I16] !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got=%b want=0", ov[I16]);
    end
    checks++;
    if (yo[I16] !== 64'd0) begin
      errors++;
      $display("FAIL reset_y_out got=%h want=0", yo[I16]);
    end
    checks++;
    if (bsy[I16] !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b want=0", bsy[I16]);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    logic [63:0] xs [4] = '{64'h00FF, 64'hFFFF, 64'h0000, 64'h0001};
    logic [63:0] yv;
    logic [63:0] want;
    int lat;
    bit a, r, s;
    for (int j = 0; j < 4; j++) begin
      xact(I16, xs[j], 1'b0, yv, lat, a, r, s);
      want = xs[j] * xs[j];
      checks++;
      if (!r || yv !== want) begin
        errors++;
        $display("FAIL square_%h got=%h want=%h", xs[j], yv, want);
      end
      checks++;
      if (lat != lat_model(xs[j], 16)) begin
        errors++;
        $display("FAIL latency_%h got=%0d want=%0d", xs[j], lat,
                 lat_model(xs[j], 16));
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [63:0] hold;
    xin[I16] = 32'h1234;
    iv[I16]  = 1'b1;
    step();
    iv[I16] = 1'b0;
    n = 0;
    while (!ov[I16] && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (!ov[I16] || yo[I16] !== 64'h014B5A90) begin
      errors++;
      $display("FAIL bp_result got=%h want=014b5a90", yo[I16]);
    end
    hold = yo[I16];
    iv[I16]  = 1'b1;
    xin[I16] = 32'h5555;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (yo[I16] !== 64'h014B5A90 || irdy[I16] !== 1'b0 ||
          ov[I16] !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall y=%h in_ready=%b out_valid=%b want y=014b5a90 0 1",
                 yo[I16], irdy[I16], ov[I16]);
      end
    end
    ord[I16] = 1'b1;
    step();
    ord[I16] = 1'b0;
    iv[I16]  = 1'b0;
    checks++;
    if (irdy[I16] !== 1'b1 || ov[I16] !== 1'b0 || yo[I16] !== hold) begin
      errors++;
      $display("FAIL bp_release in_ready=%b out_valid=%b y=%h want 1 0 %h",
               irdy[I16], ov[I16], yo[I16], hold);
    end
    step();
  endtask

  task automatic test_abort();
    logic [63:0] yv;
    int lat;
    bit a, r, s;
    bit seen;
    xin[I16] = 32'hABCD;
    iv[I16]  = 1'b1;
    step();
    iv[I16] = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (irdy[I16] !== 1'b1 || ov[I16] !== 1'b0 || bsy[I16] !== 1'b0 ||
        yo[I16] !== 64'd0) begin
      errors++;
      $display("FAIL abort_reset in_ready=%b out_valid=%b busy=%b y=%h want 1 0 0 0",
               irdy[I16], ov[I16], bsy[I16], yo[I16]);
    end
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (ov[I16]) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_result got out_valid=1 want 0");
    end
    xact(I16, 64'd3, 1'b0, yv, lat, a, r, s);
    checks++;
    if (!r || yv !== 64'd9) begin
      errors++;
      $display("FAIL abort_next got=%h want=9", yv);
    end
  endtask

  task automatic test_random();
    int cnt_in;
    int cnt_out;
    int i;
    int w;
    int lat;
    logic [63:0] mask;
    logic [63:0] x;
    logic [63:0] yv;
    bit a, r, s;
    cnt_in  = 0;
    cnt_out = 0;
    for (int t = 0; t < 1000; t++) begin
      i    = int'($urandom % 4);
      w    = wtab[i];
      mask = (w == 32) ? 64'hFFFF_FFFF : ((64'd1 << w) - 64'd1);
      case ($urandom % 8)
        0:       x = 64'd0;
        1:       x = mask;
        2:       x = (64'($urandom) >> ($urandom % 32)) & mask;
        default: x = 64'($urandom) & mask;
      endcase
      xact(i, x, 1'b1, yv, lat, a, r, s);
      if (a) cnt_in++;
      if (r) cnt_out++;
      checks++;
      if (!r || yv !== x * x) begin
        errors++;
        $display("FAIL rand_w%0d_x%h got=%h want=%h", w, x, yv, x * x);
      end
      checks++;
      if (lat != lat_model(x, w)) begin
        errors++;
        $display("FAIL rand_lat_w%0d_x%h got=%0d want=%0d", w, x, lat,
                 lat_model(x, w));
      end
      checks++;
      if (!s) begin
        errors++;
        $display("FAIL rand_hold_w%0d_x%h got=unstable want=stable", w, x);
      end
    end
    checks++;
    if (cnt_in != cnt_out || cnt_in != 1000) begin
      errors++;
      $display("FAIL rand_counts got in=%0d out=%0d want 1000 1000",
               cnt_in, cnt_out);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iv[i]  = 1'b0;
      ord[i] = 1'b0;
      xin[i] = '0;
    end
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
